// File: rtl/trace_pkg.sv
// Shared types and constants for the trace capture buffer.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int unsigned CFG_ENABLE_BIT = 0;
  localparam int unsigned CFG_CLEAR_BIT  = 1;

endpackage

// File: rtl/trace_buffer_ram.sv
// Simple dual-port trace storage: one write port, one read port with a registered, enabled read.
module trace_buffer_ram #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // rdata only changes on re, so the top can park a prefetched entry here.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_buffer.sv
// Circular trace capture buffer with oldest-first word-serial drain.
// Optional TRACE_BUFFER_STOP_ON_FULL_EN: stop writing when full and count dropped vectors.
module trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned N                  = 8,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned BUFFER_SIZE        = 64,
  parameter logic [7:0]  PERSONAL_CONFIG_ID = 8'd0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tracing,
  input  logic                    valid_in,
  input  logic [DATA_WIDTH*N-1:0] vector_in,
  input  logic [7:0]              configId,
  input  logic [7:0]              configData,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
`ifdef TRACE_BUFFER_STOP_ON_FULL_EN
  output logic [15:0]             dropped,
`endif
  output logic                    busy
);

  localparam int unsigned AW  = $clog2(BUFFER_SIZE);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned WIW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(BUFFER_SIZE);
  localparam logic [WIW-1:0] LAST_W   = WIW'(N - 1);

  state_t state, state_d;

  logic                    enable;
  logic [AW-1:0]           wr_ptr;
  logic [CW-1:0]           count;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           reads_left;
  logic [CW-1:0]           ent_left;
  logic                    q_valid;
  logic [DATA_WIDTH*N-1:0] sr;
  logic [WIW-1:0]          word_idx;
  logic                    sr_last;
  logic [DATA_WIDTH*N-1:0] ram_q;

  logic cfg_wr, cfg_clear, full, wr_en, drop_en;
  logic xfer, sr_end, load, issue, start_cap, start_drain;
  logic unused_cfg;

  assign unused_cfg = ^configData[7:2];

  always_comb begin
    cfg_wr    = (configId == PERSONAL_CONFIG_ID);
    cfg_clear = cfg_wr && configData[CFG_CLEAR_BIT];
    full      = (count == FULL_CNT);
    xfer      = rd_valid && rd_ready;
    sr_end    = xfer && (word_idx == LAST_W);
    load      = q_valid && (!rd_valid || sr_end);
    issue     = (state == DRAIN) && (reads_left != '0) && (!q_valid || load);
`ifdef TRACE_BUFFER_STOP_ON_FULL_EN
    wr_en     = (state == CAPTURE) && tracing && valid_in && !cfg_clear && !full;
    drop_en   = (state == CAPTURE) && tracing && valid_in && !cfg_clear && full;
`else
    wr_en     = (state == CAPTURE) && tracing && valid_in && !cfg_clear;
    drop_en   = 1'b0;
`endif

    state_d = state;
    unique case (state)
      IDLE:    if (tracing && enable) state_d = CAPTURE;
      CAPTURE: if (!tracing) state_d = ((count != '0) && !cfg_clear) ? DRAIN : IDLE;
      DRAIN:   if (sr_end && sr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    start_cap   = (state == IDLE) && (state_d == CAPTURE);
    start_drain = (state == CAPTURE) && (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      enable     <= 1'b1;
      wr_ptr     <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      reads_left <= '0;
      ent_left   <= '0;
      q_valid    <= 1'b0;
      sr         <= '0;
      word_idx   <= '0;
      sr_last    <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      state <= state_d;
      if (cfg_wr && state == IDLE) enable <= configData[CFG_ENABLE_BIT];

      if (start_cap || (cfg_clear && state != DRAIN)) begin
        wr_ptr <= '0;
        count  <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (!full) count <= count + 1'b1;
      end

      // Oldest entry sits count slots behind the write pointer (mod depth).
      if (start_drain) begin
        rd_ptr     <= wr_ptr - count[AW-1:0];
        reads_left <= count;
      end else if (issue) begin
        rd_ptr     <= rd_ptr + 1'b1;
        reads_left <= reads_left - 1'b1;
      end

      if (start_drain)  ent_left <= count;
      else if (load)    ent_left <= ent_left - 1'b1;

      q_valid <= issue || (q_valid && !load);

      if (load) begin
        sr       <= ram_q;
        rd_valid <= 1'b1;
        word_idx <= '0;
        sr_last  <= (ent_left == CW'(1));
      end else if (xfer) begin
        if (word_idx == LAST_W) begin
          rd_valid <= 1'b0;
        end else begin
          sr       <= sr >> DATA_WIDTH;
          word_idx <= word_idx + 1'b1;
        end
      end
    end
  end

`ifdef TRACE_BUFFER_STOP_ON_FULL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        dropped <= '0;
    else if (start_cap)                dropped <= '0;
    else if (drop_en && dropped != '1) dropped <= dropped + 1'b1;
  end
`endif

  assign rd_data = sr[DATA_WIDTH-1:0];
  assign rd_last = rd_valid && sr_last && (word_idx == LAST_W);
  assign busy    = (state != IDLE);

  trace_buffer_ram #(
    .WIDTH (DATA_WIDTH * N),
    .DEPTH (BUFFER_SIZE),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (vector_in),
    .re    (issue),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_trace_buffer.sv
// Directed self-checking bench for trace_buffer (N=8, DATA_WIDTH=32, BUFFER_SIZE=64).
module tb_trace_buffer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tracing = 1'b0;
  logic         valid_in = 1'b0;
  logic [255:0] vector_in = '0;
  logic [7:0]   configId = 8'hFF;
  logic [7:0]   configData = 8'h00;
  logic         rd_ready = 1'b0;
  logic         rd_valid;
  logic [31:0]  rd_data;
  logic         rd_last;
  logic         busy;
`ifdef TRACE_BUFFER_STOP_ON_FULL_EN
  logic [15:0]  dropped;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] got[$];
  int last_pos, last_cnt, first_c, last_c, hold_bad;
  bit timed_out;

  always #5 clk = ~clk;

  trace_buffer #(
    .N                  (8),
    .DATA_WIDTH         (32),
    .BUFFER_SIZE        (64),
    .PERSONAL_CONFIG_ID (8'd0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tracing    (tracing),
    .valid_in   (valid_in),
    .vector_in  (vector_in),
    .configId   (configId),
    .configData (configData),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
`ifdef TRACE_BUFFER_STOP_ON_FULL_EN
    .dropped    (dropped),
`endif
    .busy       (busy)
  );

  function automatic logic [255:0] mkvec(input int unsigned e);
    logic [255:0] v;
    for (int unsigned k = 0; k < 8; k++) v[k*32 +: 32] = 32'(e * 8 + k);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the tracing-low edge (first DRAIN cycle if anything was stored).
  task automatic do_capture(input int unsigned nvec, input int unsigned base);
    tracing = 1'b1;
    step();
    for (int unsigned v = 0; v < nvec; v++) begin
      valid_in  = 1'b1;
      vector_in = mkvec(base + v);
      step();
    end
    valid_in = 1'b0;
    tracing  = 1'b0;
    step();
  endtask

  // Collects accepted words; bp selects rd_ready pattern 1,0,0,1.
  task automatic drain_collect(input int unsigned max_cycles, input bit bp);
    logic        held;
    logic [31:0] held_data;
    got.delete();
    last_pos = -1; last_cnt = 0; first_c = -1; last_c = -1; hold_bad = 0;
    timed_out = 1'b1; held = 1'b0; held_data = '0;
    for (int unsigned c = 0; c < max_cycles; c++) begin
      rd_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (held && (rd_valid !== 1'b1 || rd_data !== held_data)) hold_bad++;
      if (rd_valid === 1'b1 && first_c < 0) first_c = int'(c);
      if (rd_valid === 1'b1 && rd_ready) begin
        got.push_back(rd_data);
        if (rd_last === 1'b1) begin
          last_cnt++;
          last_pos = got.size() - 1;
          last_c = int'(c);
        end
      end
      held = rd_valid && !rd_ready;
      held_data = rd_data;
      if (rd_valid === 1'b1 && rd_ready && rd_last === 1'b1) begin
        step();
        timed_out = 1'b0;
        break;
      end
      step();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last got %b exp 0", rd_last); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data got %0h exp 0", rd_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_short_capture();
    int bad;
    do_capture(3, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL short_busy_drain got %b exp 1", busy); end
    drain_collect(100, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL short_timeout got 1 exp 0"); end
    checks++; if (first_c !== 2) begin errors++; $display("FAIL short_first_latency got %0d exp 2", first_c); end
    checks++; if (got.size() !== 24) begin errors++; $display("FAIL short_word_count got %0d exp 24", got.size()); end
    bad = 0;
    foreach (got[i]) if (got[i] !== 32'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL short_data got %0d bad words exp 0", bad); end
    checks++; if (last_pos !== 23 || last_cnt !== 1) begin errors++; $display("FAIL short_rd_last got pos %0d cnt %0d exp pos 23 cnt 1", last_pos, last_cnt); end
    checks++; if (last_c - first_c !== 23) begin errors++; $display("FAIL short_back_to_back got span %0d exp 23", last_c - first_c); end
    checks++; if (busy !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL short_idle_after got busy %b valid %b exp 0 0", busy, rd_valid); end
  endtask

  task automatic test_wrap();
    int bad;
    int unsigned exp_base;
    do_capture(70, 0);
`ifdef TRACE_BUFFER_STOP_ON_FULL_EN
    exp_base = 0;
    checks++; if (dropped !== 16'd6) begin errors++; $display("FAIL wrap_dropped got %0d exp 6", dropped); end
`else
    exp_base = 48;
`endif
    drain_collect(700, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL wrap_timeout got 1 exp 0"); end
    checks++; if (got.size() !== 512) begin errors++; $display("FAIL wrap_word_count got %0d exp 512", got.size()); end
    bad = 0;
    foreach (got[i]) if (got[i] !== 32'(exp_base + i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_data got %0d bad words first %0h exp first %0h", bad, got.size() > 0 ? got[0] : 32'hx, exp_base); end
  endtask

  task automatic test_backpressure();
    int bad;
    do_capture(2, 10);
    drain_collect(200, 1'b1);
    checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout got 1 exp 0"); end
    checks++; if (got.size() !== 16) begin errors++; $display("FAIL bp_word_count got %0d exp 16", got.size()); end
    bad = 0;
    foreach (got[i]) if (got[i] !== 32'(80 + i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_data got %0d bad words exp 0", bad); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL bp_hold_stable got %0d violations exp 0", hold_bad); end
  endtask

  task automatic test_empty_window();
    int vseen;
    vseen = 0;
    tracing = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); if (rd_valid === 1'b1) vseen++; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL empty_busy_capture got %b exp 1", busy); end
    tracing = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); if (rd_valid === 1'b1) vseen++; end
    checks++; if (vseen != 0) begin errors++; $display("FAIL empty_rd_valid got %0d cycles exp 0", vseen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_idle got busy %b exp 0", busy); end
  endtask

  task automatic test_config();
    int busy_seen;
    // disable via matching id
    configId = 8'd0; configData = 8'h00; step();
    configId = 8'hFF;
    busy_seen = 0;
    tracing = 1'b1;
    for (int unsigned v = 0; v < 5; v++) begin
      valid_in = 1'b1; vector_in = mkvec(v); step();
      if (busy !== 1'b0 || rd_valid !== 1'b0) busy_seen++;
    end
    valid_in = 1'b0; tracing = 1'b0;
    for (int i = 0; i < 6; i++) begin step(); if (busy !== 1'b0 || rd_valid !== 1'b0) busy_seen++; end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL cfg_disabled got %0d active cycles exp 0", busy_seen); end
    // mismatched id must not re-enable
    configId = 8'h12; configData = 8'h01; step();
    configId = 8'hFF; configData = 8'h00;
    busy_seen = 0;
    tracing = 1'b1;
    for (int i = 0; i < 4; i++) begin step(); if (busy !== 1'b0) busy_seen++; end
    tracing = 1'b0; step();
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL cfg_mismatch got %0d busy cycles exp 0", busy_seen); end
    // re-enable, then clear mid-capture leaves only the post-clear entry
    configId = 8'd0; configData = 8'h01; step();
    configId = 8'hFF; configData = 8'h00;
    tracing = 1'b1; step();
    for (int unsigned v = 0; v < 3; v++) begin valid_in = 1'b1; vector_in = mkvec(v); step(); end
    valid_in = 1'b0; configId = 8'd0; configData = 8'h03; step();
    configId = 8'hFF; configData = 8'h00;
    valid_in = 1'b1; vector_in = mkvec(40); step();
    valid_in = 1'b0; tracing = 1'b0; step();
    drain_collect(100, 1'b0);
    checks++; if (got.size() !== 8 || timed_out) begin errors++; $display("FAIL cfg_clear_count got %0d exp 8", got.size()); end
    checks++; if (got.size() > 0 && got[0] !== 32'd320) begin errors++; $display("FAIL cfg_clear_data got %0d exp 320", got[0]); end
  endtask

  task automatic test_reset_mid_drain();
    int bad;
    bit found;
    found = 1'b0;
    do_capture(3, 0);
    rd_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (rd_valid === 1'b1 && rd_data === 32'd5) begin found = 1'b1; break; end
      step();
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach_word5 got 0 exp 1"); end
    rst_n = 1'b0; #1;
    checks++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_async got valid %b busy %b exp 0 0", rd_valid, busy); end
    rd_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    do_capture(2, 20);
    drain_collect(100, 1'b0);
    checks++; if (got.size() !== 16 || timed_out) begin errors++; $display("FAIL rstmid_word_count got %0d exp 16", got.size()); end
    bad = 0;
    foreach (got[i]) if (got[i] !== 32'(160 + i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_data got %0d bad words exp 0", bad); end
  endtask

  initial begin
    step(); step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_short_capture();
    test_wrap();
    test_backpressure();
    test_empty_window();
    test_config();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
